// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared cause codes and FSM state type for the hazard controller
package hazard_pkg;

  typedef logic [3:0] hz_code_t;

  localparam hz_code_t HZ_NONE   = 4'h0;
  localparam hz_code_t HZ_LOAD   = 4'h1;
  localparam hz_code_t HZ_AUIPC  = 4'hA;
  localparam hz_code_t HZ_BRANCH = 4'hB;
  localparam hz_code_t HZ_MDU    = 4'hD;
  localparam hz_code_t HZ_FLUSH  = 4'hF;

  typedef enum logic {
    HZ_IDLE,
    HZ_STALL
  } hz_state_t;

endpackage

// File: rtl/hazard_stall_counter.sv
// rtl/hazard_stall_counter.sv - loadable down-counter with clear/freeze that stops at zero
module hazard_stall_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             freeze,
  input  logic             clear,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (freeze) begin
      cnt_d = cnt_q;
    end else if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;
  assign zero  = (cnt_q == '0);

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - ID/EX hazard controller: stall, bubble, flush and cause reporting
// Optional HAZARD_PERF_EN adds saturating stall/flush cycle counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW       = 5,
  parameter int CNT_W        = 3,
  parameter int LOAD_STALLS  = 2,
  parameter int AUIPC_STALLS = 2,
  parameter int CODE_W       = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [REG_AW-1:0] rs1_ID,
  input  logic [REG_AW-1:0] rs2_ID,
  input  logic              rs1_used_ID,
  input  logic              rs2_used_ID,
  input  logic [REG_AW-1:0] rd_EX,
  input  logic              load_EX,
  input  logic              auipc_MEM,
  input  logic              branch_ID,
  input  logic              branch_taken,
  input  logic              mdu_busy,
  output logic              stall_IFID,
  output logic              stall_IDEX,
  output logic              bubble_EX,
  output logic              flush,
  output logic [CODE_W-1:0] stall_code
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_flush_cnt
`endif
);

  localparam int CNT_MAX = (2 ** CNT_W) - 1;

  if (LOAD_STALLS < 1 || LOAD_STALLS > CNT_MAX) begin : g_bad_load_stalls
    $error("hazard_ctrl: LOAD_STALLS out of range 1..2^CNT_W-1");
  end
  if (AUIPC_STALLS < 1 || AUIPC_STALLS > CNT_MAX) begin : g_bad_auipc_stalls
    $error("hazard_ctrl: AUIPC_STALLS out of range 1..2^CNT_W-1");
  end

  localparam bit               LOAD_MULTI   = (LOAD_STALLS > 1);
  localparam bit               AUIPC_MULTI  = (AUIPC_STALLS > 1);
  localparam logic [CNT_W-1:0] LOAD_RELOAD  = CNT_W'(LOAD_STALLS - 1);
  localparam logic [CNT_W-1:0] AUIPC_RELOAD = CNT_W'(AUIPC_STALLS - 1);

  hz_state_t        state_q, state_d;
  hz_code_t         cause_q, cause_d;
  hz_code_t         code;
  logic             cnt_load, cnt_freeze, cnt_clear, cnt_zero;
  logic [CNT_W-1:0] cnt_load_val, cnt_count;
  logic             load_use;

  // x0 never carries a real dependency, and unread sources cannot hazard
  assign load_use = load_EX && (rd_EX != '0) &&
                    ((rs1_used_ID && (rs1_ID == rd_EX)) ||
                     (rs2_used_ID && (rs2_ID == rd_EX)));

  hazard_stall_counter #(.CNT_W(CNT_W)) u_cnt (
    .clock    (clock),
    .reset    (reset),
    .load     (cnt_load),
    .freeze   (cnt_freeze),
    .clear    (cnt_clear),
    .load_val (cnt_load_val),
    .count    (cnt_count),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d      = state_q;
    cause_d      = cause_q;
    cnt_load     = 1'b0;
    cnt_freeze   = 1'b0;
    cnt_clear    = 1'b0;
    cnt_load_val = '0;
    code         = HZ_NONE;
    stall_IFID   = 1'b0;
    stall_IDEX   = 1'b0;
    bubble_EX    = 1'b0;
    flush        = 1'b0;

    if (branch_taken) begin
      flush     = 1'b1;
      code      = HZ_FLUSH;
      cnt_clear = 1'b1;
      state_d   = HZ_IDLE;
      cause_d   = HZ_NONE;
    end else if (mdu_busy) begin
      {stall_IFID, stall_IDEX, bubble_EX} = 3'b111;
      code       = HZ_MDU;
      cnt_freeze = 1'b1;
    end else if (state_q == HZ_STALL && !cnt_zero) begin
      {stall_IFID, stall_IDEX, bubble_EX} = 3'b111;
      code = cause_q;
      if (cnt_count == CNT_W'(1)) begin
        state_d = HZ_IDLE;
      end
    end else if (auipc_MEM || load_use) begin
      {stall_IFID, stall_IDEX, bubble_EX} = 3'b111;
      code = auipc_MEM ? HZ_AUIPC : HZ_LOAD;
      if (auipc_MEM ? AUIPC_MULTI : LOAD_MULTI) begin
        cnt_load     = 1'b1;
        cnt_load_val = auipc_MEM ? AUIPC_RELOAD : LOAD_RELOAD;
        cause_d      = code;
        state_d      = HZ_STALL;
      end
    end else if (branch_ID) begin
      {stall_IFID, stall_IDEX} = 2'b11;
      code = HZ_BRANCH;
    end

    if (reset) begin
      {stall_IFID, stall_IDEX, bubble_EX, flush} = 4'b0000;
      code = HZ_NONE;
    end
  end

  assign stall_code = CODE_W'(code);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= HZ_IDLE;
      cause_q <= HZ_NONE;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_flush_q, perf_flush_d;

  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_flush_d = perf_flush_q;
    if (stall_IFID && perf_stall_q != 32'hFFFF_FFFF) perf_stall_d = perf_stall_q + 32'd1;
    if (flush && perf_flush_q != 32'hFFFF_FFFF) perf_flush_d = perf_flush_q + 32'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_flush_cnt = perf_flush_q;
`endif

endmodule
